// File: rtl/axi_cdc_src_core.sv
// Source-domain half of the AXI clock-domain crossing.
// AW/W/AR are written into local gray-pointer FIFOs that the destination
// half drains. B/R are read out of FIFOs that the destination half owns.

package axi_cdc_src_pkg;
    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } aw_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [1:0] id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_chan_t;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     w_ready;
        b_chan_t  b;
        logic     b_valid;
        logic     ar_ready;
        r_chan_t  r;
        logic     r_valid;
    } axi_resp_t;
endpackage

// Write side of one channel: local storage, binary/gray write pointer,
// synchronized read pointer from the destination for the full check.
module axi_cdc_src_wr #(
    parameter type         T          = logic,
    parameter int unsigned LogDepth   = 1,
    parameter int unsigned SyncStages = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  T                  i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output T                  o_fifo [2**LogDepth],
    output logic [LogDepth:0] o_wptr,
    input  logic [LogDepth:0] i_rptr
);
    localparam int unsigned Depth = 2**LogDepth;
    localparam logic [LogDepth:0] MsbSet = {1'b1, {LogDepth{1'b0}}};

    logic [LogDepth:0] r_wptr;
    logic [LogDepth:0] r_gray_wptr;
    logic [LogDepth:0] r_sync [SyncStages];
    T                  r_data [Depth];
    logic [LogDepth:0] w_wptr_nxt;
    logic [LogDepth:0] w_rptr_bin;
    logic              w_full;
    logic              w_push;

    // Gray-to-binary of the last synchronizer stage
    always_comb begin
        w_rptr_bin = r_sync[SyncStages-1];
        for (int i = 1; i <= int'(LogDepth); i++)
            w_rptr_bin = w_rptr_bin ^ (r_sync[SyncStages-1] >> i);
    end

    // Full when the pointers differ only in the wrap bit
    assign w_full     = (r_wptr == (w_rptr_bin ^ MsbSet));
    assign o_ready    = !w_full;
    assign w_push     = i_valid && !w_full;
    assign w_wptr_nxt = r_wptr + (LogDepth+1)'(1);
    assign o_fifo     = r_data;
    assign o_wptr     = r_gray_wptr;

    // Synchronize the destination's gray read pointer
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(SyncStages); i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= i_rptr;
            for (int i = 1; i < int'(SyncStages); i++) r_sync[i] <= r_sync[i-1];
        end
    end

    // Push: slot and pointer land together so data is stable before the pointer is seen
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr      <= '0;
            r_gray_wptr <= '0;
            for (int i = 0; i < int'(Depth); i++) r_data[i] <= '0;
        end else if (w_push) begin
            r_data[r_wptr[LogDepth-1:0]] <= i_data;
            r_wptr                       <= w_wptr_nxt;
            r_gray_wptr                  <= w_wptr_nxt ^ (w_wptr_nxt >> 1);
        end
    end
endmodule

// Read side of one channel: storage lives in the destination, we only
// own the read pointer and a synchronized copy of its write pointer.
module axi_cdc_src_rd #(
    parameter type         T          = logic,
    parameter int unsigned LogDepth   = 1,
    parameter int unsigned SyncStages = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output T                  o_data,
    output logic              o_valid,
    input  logic              i_ready,
    input  T                  i_fifo [2**LogDepth],
    input  logic [LogDepth:0] i_wptr,
    output logic [LogDepth:0] o_rptr
);
    logic [LogDepth:0] r_rptr;
    logic [LogDepth:0] r_gray_rptr;
    logic [LogDepth:0] r_sync [SyncStages];
    logic [LogDepth:0] w_rptr_nxt;
    logic [LogDepth:0] w_wptr_bin;
    logic              w_pop;

    // Gray-to-binary of the last synchronizer stage
    always_comb begin
        w_wptr_bin = r_sync[SyncStages-1];
        for (int i = 1; i <= int'(LogDepth); i++)
            w_wptr_bin = w_wptr_bin ^ (r_sync[SyncStages-1] >> i);
    end

    assign o_valid    = (r_rptr != w_wptr_bin);
    assign o_data     = i_fifo[r_rptr[LogDepth-1:0]];
    assign w_pop      = o_valid && i_ready;
    assign w_rptr_nxt = r_rptr + (LogDepth+1)'(1);
    assign o_rptr     = r_gray_rptr;

    // Synchronize the destination's gray write pointer
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(SyncStages); i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= i_wptr;
            for (int i = 1; i < int'(SyncStages); i++) r_sync[i] <= r_sync[i-1];
        end
    end

    // Pop: advance binary and gray read pointers together
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rptr      <= '0;
            r_gray_rptr <= '0;
        end else if (w_pop) begin
            r_rptr      <= w_rptr_nxt;
            r_gray_rptr <= w_rptr_nxt ^ (w_rptr_nxt >> 1);
        end
    end
endmodule

module axi_cdc_src_core #(
    parameter int unsigned LogDepth   = 1,
    parameter int unsigned SyncStages = 2,
    parameter type aw_chan_t  = axi_cdc_src_pkg::aw_chan_t,
    parameter type w_chan_t   = axi_cdc_src_pkg::w_chan_t,
    parameter type b_chan_t   = axi_cdc_src_pkg::b_chan_t,
    parameter type ar_chan_t  = axi_cdc_src_pkg::ar_chan_t,
    parameter type r_chan_t   = axi_cdc_src_pkg::r_chan_t,
    parameter type axi_req_t  = axi_cdc_src_pkg::axi_req_t,
    parameter type axi_resp_t = axi_cdc_src_pkg::axi_resp_t
) (
    input  logic              src_clk_i,
    input  logic              src_rst_i,
    input  axi_req_t          src_req_i,
    output axi_resp_t         src_resp_o,
    output aw_chan_t          async_data_master_aw_data_o [2**LogDepth],
    output logic [LogDepth:0] async_data_master_aw_wptr_o,
    input  logic [LogDepth:0] async_data_master_aw_rptr_i,
    output w_chan_t           async_data_master_w_data_o  [2**LogDepth],
    output logic [LogDepth:0] async_data_master_w_wptr_o,
    input  logic [LogDepth:0] async_data_master_w_rptr_i,
    output ar_chan_t          async_data_master_ar_data_o [2**LogDepth],
    output logic [LogDepth:0] async_data_master_ar_wptr_o,
    input  logic [LogDepth:0] async_data_master_ar_rptr_i,
    input  b_chan_t           async_data_master_b_data_i  [2**LogDepth],
    input  logic [LogDepth:0] async_data_master_b_wptr_i,
    output logic [LogDepth:0] async_data_master_b_rptr_o,
    input  r_chan_t           async_data_master_r_data_i  [2**LogDepth],
    input  logic [LogDepth:0] async_data_master_r_wptr_i,
    output logic [LogDepth:0] async_data_master_r_rptr_o
);
    logic    w_aw_ready, w_w_ready, w_ar_ready, w_b_valid, w_r_valid;
    b_chan_t w_b;
    r_chan_t w_r;

    axi_cdc_src_wr #(.T(aw_chan_t), .LogDepth(LogDepth), .SyncStages(SyncStages)) u_aw (
        .i_clk(src_clk_i), .i_rst(src_rst_i),
        .i_data(src_req_i.aw), .i_valid(src_req_i.aw_valid), .o_ready(w_aw_ready),
        .o_fifo(async_data_master_aw_data_o), .o_wptr(async_data_master_aw_wptr_o),
        .i_rptr(async_data_master_aw_rptr_i)
    );

    axi_cdc_src_wr #(.T(w_chan_t), .LogDepth(LogDepth), .SyncStages(SyncStages)) u_w (
        .i_clk(src_clk_i), .i_rst(src_rst_i),
        .i_data(src_req_i.w), .i_valid(src_req_i.w_valid), .o_ready(w_w_ready),
        .o_fifo(async_data_master_w_data_o), .o_wptr(async_data_master_w_wptr_o),
        .i_rptr(async_data_master_w_rptr_i)
    );

    axi_cdc_src_wr #(.T(ar_chan_t), .LogDepth(LogDepth), .SyncStages(SyncStages)) u_ar (
        .i_clk(src_clk_i), .i_rst(src_rst_i),
        .i_data(src_req_i.ar), .i_valid(src_req_i.ar_valid), .o_ready(w_ar_ready),
        .o_fifo(async_data_master_ar_data_o), .o_wptr(async_data_master_ar_wptr_o),
        .i_rptr(async_data_master_ar_rptr_i)
    );

    axi_cdc_src_rd #(.T(b_chan_t), .LogDepth(LogDepth), .SyncStages(SyncStages)) u_b (
        .i_clk(src_clk_i), .i_rst(src_rst_i),
        .o_data(w_b), .o_valid(w_b_valid), .i_ready(src_req_i.b_ready),
        .i_fifo(async_data_master_b_data_i), .i_wptr(async_data_master_b_wptr_i),
        .o_rptr(async_data_master_b_rptr_o)
    );

    axi_cdc_src_rd #(.T(r_chan_t), .LogDepth(LogDepth), .SyncStages(SyncStages)) u_r (
        .i_clk(src_clk_i), .i_rst(src_rst_i),
        .o_data(w_r), .o_valid(w_r_valid), .i_ready(src_req_i.r_ready),
        .i_fifo(async_data_master_r_data_i), .i_wptr(async_data_master_r_wptr_i),
        .o_rptr(async_data_master_r_rptr_o)
    );

    // Collect per-channel handshakes and payloads into the response struct
    always_comb begin
        src_resp_o          = '0;
        src_resp_o.aw_ready = w_aw_ready;
        src_resp_o.w_ready  = w_w_ready;
        src_resp_o.ar_ready = w_ar_ready;
        src_resp_o.b        = w_b;
        src_resp_o.b_valid  = w_b_valid;
        src_resp_o.r        = w_r;
        src_resp_o.r_valid  = w_r_valid;
    end
endmodule

// File: tb/tb_axi_cdc_src_core.sv
// Scoreboard bench for axi_cdc_src_core with LogDepth=1, SyncStages=2.
module tb_axi_cdc_src_core;
    import axi_cdc_src_pkg::*;

    localparam int K_AW_RDY = 0,  K_W_RDY = 1,  K_AR_RDY = 2,  K_B_VLD = 3,  K_R_VLD = 4;
    localparam int K_AW_WP  = 5,  K_W_WP  = 6,  K_AR_WP  = 7,  K_B_RP  = 8,  K_R_RP  = 9;
    localparam int K_AW_D0  = 10, K_AW_D1 = 11, K_W_D0   = 12, K_W_D1  = 13, K_B_RESP = 14;
    localparam int K_R_DATA = 15;

    typedef struct {
        string       name;
        int          kind;
        logic [63:0] exp;
    } sb_t;

    logic      clk = 1'b0;
    logic      clk_en = 1'b0;
    logic      rst;
    axi_req_t  req;
    axi_resp_t rsp;
    aw_chan_t  aw_data [2];
    w_chan_t   w_data  [2];
    ar_chan_t  ar_data [2];
    b_chan_t   b_data  [2];
    r_chan_t   r_data  [2];
    logic [1:0] aw_wptr, w_wptr, ar_wptr, b_rptr, r_rptr;
    logic [1:0] aw_rptr, w_rptr, ar_rptr, b_wptr, r_wptr;

    sb_t         sb_q [$];
    logic [1:0]  b_q  [$];
    logic [31:0] r_q  [$];
    int checks = 0;
    int errors = 0;

    axi_cdc_src_core dut (
        .src_clk_i(clk), .src_rst_i(rst),
        .src_req_i(req), .src_resp_o(rsp),
        .async_data_master_aw_data_o(aw_data), .async_data_master_aw_wptr_o(aw_wptr),
        .async_data_master_aw_rptr_i(aw_rptr),
        .async_data_master_w_data_o(w_data), .async_data_master_w_wptr_o(w_wptr),
        .async_data_master_w_rptr_i(w_rptr),
        .async_data_master_ar_data_o(ar_data), .async_data_master_ar_wptr_o(ar_wptr),
        .async_data_master_ar_rptr_i(ar_rptr),
        .async_data_master_b_data_i(b_data), .async_data_master_b_wptr_i(b_wptr),
        .async_data_master_b_rptr_o(b_rptr),
        .async_data_master_r_data_i(r_data), .async_data_master_r_wptr_i(r_wptr),
        .async_data_master_r_rptr_o(r_rptr)
    );

    always #5 if (clk_en) clk = ~clk;

    function automatic logic [63:0] act(int k);
        case (k)
            K_AW_RDY: return 64'(rsp.aw_ready);
            K_W_RDY:  return 64'(rsp.w_ready);
            K_AR_RDY: return 64'(rsp.ar_ready);
            K_B_VLD:  return 64'(rsp.b_valid);
            K_R_VLD:  return 64'(rsp.r_valid);
            K_AW_WP:  return 64'(aw_wptr);
            K_W_WP:   return 64'(w_wptr);
            K_AR_WP:  return 64'(ar_wptr);
            K_B_RP:   return 64'(b_rptr);
            K_R_RP:   return 64'(r_rptr);
            K_AW_D0:  return 64'(aw_data[0].addr);
            K_AW_D1:  return 64'(aw_data[1].addr);
            K_W_D0:   return 64'(w_data[0].data);
            K_W_D1:   return 64'(w_data[1].data);
            K_B_RESP: return 64'(rsp.b.resp);
            K_R_DATA: return 64'(rsp.r.data);
            default:  return 64'hDEAD;
        endcase
    endfunction

    function automatic logic [1:0] gray(int b);
        return 2'((b ^ (b >> 1)) & 3);
    endfunction

    task automatic expect_v(input string n, input int k, input logic [63:0] v);
        sb_t e;
        e.name = n; e.kind = k; e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every queued expectation against the live outputs
    initial begin
        sb_t e;
        logic [63:0] a;
        forever begin
            wait (sb_q.size() != 0);
            e = sb_q.pop_front();
            a = act(e.kind);
            checks++;
            if (a !== e.exp) begin
                errors++;
                $display("FAIL %s: got %0h want %0h at %0t", e.name, a, e.exp, $time);
            end
        end
    end

    // Monitor: B/R handshakes pop the expected response beats
    initial begin
        forever begin
            @(negedge clk);
            if (rsp.b_valid && req.b_ready) begin
                checks++;
                if (b_q.size() == 0) begin
                    errors++;
                    $display("FAIL b_beat: unexpected beat resp %0h", rsp.b.resp);
                end else begin
                    logic [1:0] eb;
                    eb = b_q.pop_front();
                    if (rsp.b.resp !== eb) begin
                        errors++;
                        $display("FAIL b_beat: got resp %0h want %0h", rsp.b.resp, eb);
                    end
                end
            end
            if (rsp.r_valid && req.r_ready) begin
                checks++;
                if (r_q.size() == 0) begin
                    errors++;
                    $display("FAIL r_beat: unexpected beat data %0h", rsp.r.data);
                end else begin
                    logic [31:0] er;
                    er = r_q.pop_front();
                    if (rsp.r.data !== er) begin
                        errors++;
                        $display("FAIL r_beat: got data %0h want %0h", rsp.r.data, er);
                    end
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: timeout, summary follows");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        req = '0;
        aw_rptr = '0; w_rptr = '0; ar_rptr = '0; b_wptr = '0; r_wptr = '0;
        b_data[0] = '{id: 2'd1, resp: 2'b01};
        b_data[1] = '0;
        r_data[0] = '0;
        r_data[1] = '0;

        // Reset with no clock running
        #2;
        expect_v("rst_aw_ready", K_AW_RDY, 1);
        expect_v("rst_w_ready",  K_W_RDY,  1);
        expect_v("rst_ar_ready", K_AR_RDY, 1);
        expect_v("rst_b_valid",  K_B_VLD,  0);
        expect_v("rst_r_valid",  K_R_VLD,  0);
        expect_v("rst_aw_wptr",  K_AW_WP,  0);
        expect_v("rst_w_wptr",   K_W_WP,   0);
        expect_v("rst_ar_wptr",  K_AR_WP,  0);
        expect_v("rst_b_rptr",   K_B_RP,   0);
        expect_v("rst_r_rptr",   K_R_RP,   0);
        expect_v("rst_aw_data0", K_AW_D0,  0);
        expect_v("rst_b_payload", K_B_RESP, 2'b01);
        #2 rst = 1'b0;
        #2 clk_en = 1'b1;

        // Fill AW with the read pointer held at 0
        req.aw.addr = 32'h10; req.aw_valid = 1'b1;
        tick();
        expect_v("fill1_wptr",  K_AW_WP,  2'b01);
        expect_v("fill1_data0", K_AW_D0,  32'h10);
        expect_v("fill1_ready", K_AW_RDY, 1);
        req.aw.addr = 32'h20;
        tick();
        expect_v("fill2_wptr",  K_AW_WP,  2'b11);
        expect_v("fill2_data1", K_AW_D1,  32'h20);
        expect_v("fill2_ready", K_AW_RDY, 0);
        req.aw.addr = 32'h30;
        tick();
        expect_v("full_hold_wptr",  K_AW_WP, 2'b11);
        expect_v("full_hold_data0", K_AW_D0, 32'h10);
        req.aw_valid = 1'b0;

        // Free one slot: ready returns after exactly two edges
        aw_rptr = 2'b01;
        tick();
        expect_v("free_edge1_ready", K_AW_RDY, 0);
        tick();
        expect_v("free_edge2_ready", K_AW_RDY, 1);
        req.aw.addr = 32'h30; req.aw_valid = 1'b1;
        tick();
        req.aw_valid = 1'b0;
        expect_v("push3_wptr",  K_AW_WP,  2'b10);
        expect_v("push3_data0", K_AW_D0,  32'h30);
        expect_v("push3_data1", K_AW_D1,  32'h20);
        expect_v("push3_ready", K_AW_RDY, 0);

        // B receive and pop
        b_data[0].resp = 2'b10;
        b_wptr = 2'b01;
        tick();
        expect_v("b_edge1_valid", K_B_VLD, 0);
        tick();
        expect_v("b_edge2_valid", K_B_VLD, 1);
        expect_v("b_resp",        K_B_RESP, 2'b10);
        b_q.push_back(2'b10);
        req.b_ready = 1'b1;
        tick();
        req.b_ready = 1'b0;
        expect_v("b_pop_rptr",  K_B_RP,  2'b01);
        expect_v("b_pop_valid", K_B_VLD, 0);

        // R receive: two beats, second from slot 1
        r_data[0].data = 32'hCAFE_F00D;
        r_data[1].data = 32'h1234_5678;
        r_wptr = 2'b01;
        tick();
        expect_v("r_edge1_valid", K_R_VLD, 0);
        tick();
        expect_v("r_edge2_valid", K_R_VLD, 1);
        r_q.push_back(32'hCAFE_F00D);
        req.r_ready = 1'b1;
        tick();
        req.r_ready = 1'b0;
        expect_v("r_pop1_rptr",  K_R_RP,  2'b01);
        expect_v("r_pop1_valid", K_R_VLD, 0);
        r_wptr = 2'b11;
        tick();
        tick();
        expect_v("r_beat2_valid", K_R_VLD,  1);
        expect_v("r_beat2_data",  K_R_DATA, 32'h1234_5678);
        r_q.push_back(32'h1234_5678);
        req.r_ready = 1'b1;
        tick();
        req.r_ready = 1'b0;
        expect_v("r_pop2_rptr", K_R_RP, 2'b11);

        // W wrap: push/drain rounds with the read pointer echoed back
        for (int i = 0; i < 5; i++) begin
            expect_v($sformatf("wrap%0d_ready", i), K_W_RDY, 1);
            req.w.data = 32'h100 + 32'(i); req.w_valid = 1'b1;
            tick();
            req.w_valid = 1'b0;
            expect_v($sformatf("wrap%0d_wptr", i), K_W_WP, gray((i + 1) % 4));
            expect_v($sformatf("wrap%0d_slot", i), (i % 2 == 0) ? K_W_D0 : K_W_D1,
                     64'(32'h100 + 32'(i)));
            w_rptr = gray((i + 1) % 4);
            tick();
            tick();
        end

        // Asynchronous reset with an AR entry queued
        req.ar.addr = 32'h40; req.ar_valid = 1'b1;
        tick();
        req.ar_valid = 1'b0;
        expect_v("ar_queued_wptr", K_AR_WP, 2'b01);
        #3 rst = 1'b1;
        #1;
        expect_v("arst_ar_wptr",  K_AR_WP,  0);
        expect_v("arst_ar_ready", K_AR_RDY, 1);
        expect_v("arst_aw_ready", K_AW_RDY, 1);
        expect_v("arst_aw_wptr",  K_AW_WP,  0);
        expect_v("arst_aw_data1", K_AW_D1,  0);
        expect_v("arst_b_rptr",   K_B_RP,   0);
        expect_v("arst_w_wptr",   K_W_WP,   0);
        #20;

        checks++;
        if (sb_q.size() != 0 || b_q.size() != 0 || r_q.size() != 0) begin
            errors++;
            $display("FAIL drain: left sb %0d b %0d r %0d want 0 0 0",
                     sb_q.size(), b_q.size(), r_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
